// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default widths for the instruction fetch unit.
// Combinational only; no flow control.
package fetch_pkg;

  localparam int IMEM_ADDR_W = 4;
  localparam int INSTR_W     = 12;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc.sv
// Program counter: load has priority over increment, increment wraps modulo 2^ADDR_W.
// One-cycle update latency; no backpressure (the FSM gates inc/load).
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the PC, reads imem, hands words out on valid/ready; first word MEM_LAT+1 cycles after reset.
// Holds instr stable under backpressure; optional accept counter via FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = IMEM_ADDR_W,
  parameter int DATA_W  = INSTR_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       accept_cnt
`endif
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  fetch_state_t     state;
  logic [CNT_W-1:0] wait_cnt;
  logic             handshake;
  logic             pc_inc;
  logic             pc_load;

  assign handshake = (state == HOLD) && instr_valid && instr_ready;

  // Halt outranks a jump in FETCH, so the PC must not move when both are seen there.
  always_comb begin
    pc_inc  = (state == WAIT) && !jump_en && (wait_cnt == '0);
    pc_load = jump_en && (state != HALTED) && !((state == FETCH) && halt);
  end

  fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .inc       (pc_inc),
    .load      (pc_load),
    .load_addr (jump_addr),
    .pc        (imem_addr)
  );

  // Reset sits in FETCH, so the strobe is masked while reset is held.
  assign imem_rd_en = (state == FETCH) && !halt && !reset;
  assign halted     = (state == HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      wait_cnt    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (halt) begin
            state <= HALTED;
          end else if (jump_en) begin
            state <= FETCH;
          end else begin
            state    <= WAIT;
            wait_cnt <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (jump_en) begin
            state <= FETCH;
          end else if (wait_cnt == '0) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        HOLD: begin
          if (jump_en || handshake) begin
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        HALTED: begin
          instr_valid <= 1'b0;
          state       <= HALTED;
        end
        default: begin
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      accept_cnt <= 16'd0;
    end else if (handshake && (accept_cnt != 16'hFFFF)) begin
      accept_cnt <= accept_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_instr_fetch_unit;

  localparam int MEM_LAT = 1;
  localparam int PER     = MEM_LAT + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  imem_addr;
  logic        imem_rd_en;
  logic [11:0] imem_rdata = 12'h000;
  logic [11:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        jump_en = 1'b0;
  logic [3:0]  jump_addr = 4'h0;
  logic        halt = 1'b0;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] accept_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  instr_fetch_unit #(
    .ADDR_W  (4),
    .DATA_W  (12),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rd_en  (imem_rd_en),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .accept_cnt  (accept_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: one-cycle registered read returning 12'h100 + address.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= 12'h100 + {8'h00, imem_addr};
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    jump_en   = 1'b0;
    halt      = 1'b0;
    jump_addr = 4'h0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < max) begin
      sync();
      n++;
      if (instr_valid === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL wait_valid: instr_valid not seen within %0d cycles", max);
    end
  endtask

  task automatic test_reset();
    #3;
    reset = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en got=%b exp=0", imem_rd_en); end
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (instr !== 12'h000) begin fails++; $display("FAIL reset_instr got=%h exp=000", instr); end
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (imem_addr !== 4'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (accept_cnt !== 16'd0) begin fails++; $display("FAIL reset_acc got=%0d exp=0", accept_cnt); end
`endif
  endtask

  task automatic test_streaming();
    bit exp_rd;
    bit exp_v;
    int k;
    instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 3 * PER; c++) begin
      exp_rd = (c % PER == 0);
      exp_v  = (c % PER == PER - 1);
      k      = c / PER;
      checks++; if (imem_rd_en !== exp_rd) begin fails++; $display("FAIL stream_rd_en c=%0d got=%b exp=%b", c, imem_rd_en, exp_rd); end
      if (exp_rd) begin
        checks++; if (imem_addr !== 4'(k)) begin fails++; $display("FAIL stream_addr c=%0d got=%h exp=%h", c, imem_addr, 4'(k)); end
      end
      checks++; if (instr_valid !== exp_v) begin fails++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, instr_valid, exp_v); end
      if (exp_v) begin
        checks++; if (instr !== 12'h100 + 12'(k)) begin fails++; $display("FAIL stream_instr c=%0d got=%h exp=%h", c, instr, 12'h100 + 12'(k)); end
      end
      sync();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < PER - 1; c++) sync();
    for (int k = 0; k < 5; k++) begin
      checks++; if (instr !== 12'h100) begin fails++; $display("FAIL bp_instr k=%0d got=%h exp=100", k, instr); end
      checks++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_valid k=%0d got=%b exp=1", k, instr_valid); end
      checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL bp_rd_en k=%0d got=%b exp=0", k, imem_rd_en); end
      checks++; if (imem_addr !== 4'h1) begin fails++; $display("FAIL bp_pc k=%0d got=%h exp=1", k, imem_addr); end
      sync();
    end
    instr_ready = 1'b1;
    sync();
    checks++; if (imem_rd_en !== 1'b1) begin fails++; $display("FAIL bp_refetch_rd got=%b exp=1", imem_rd_en); end
    checks++; if (imem_addr !== 4'h1) begin fails++; $display("FAIL bp_refetch_addr got=%h exp=1", imem_addr); end
    wait_valid(10, ok);
    if (ok) begin
      checks++; if (instr !== 12'h101) begin fails++; $display("FAIL bp_next_instr got=%h exp=101", instr); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    instr_ready = 1'b0;
    do_reset();
    jump_en   = 1'b1;
    jump_addr = 4'hF;
    sync();
    jump_en = 1'b0;
    checks++; if (imem_addr !== 4'hF || imem_rd_en !== 1'b1) begin fails++; $display("FAIL wrap_jump_fetch got addr=%h rd=%b exp addr=f rd=1", imem_addr, imem_rd_en); end
    wait_valid(10, ok);
    if (ok) begin
      checks++; if (instr !== 12'h10F) begin fails++; $display("FAIL wrap_instr_f got=%h exp=10f", instr); end
      checks++; if (imem_addr !== 4'h0) begin fails++; $display("FAIL wrap_pc got=%h exp=0", imem_addr); end
    end
    instr_ready = 1'b1;
    sync();
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 4'h0) begin fails++; $display("FAIL wrap_refetch got addr=%h rd=%b exp addr=0 rd=1", imem_addr, imem_rd_en); end
    wait_valid(10, ok);
    if (ok) begin
      checks++; if (instr !== 12'h100) begin fails++; $display("FAIL wrap_instr_0 got=%h exp=100", instr); end
    end
  endtask

  task automatic test_jump_wait();
    bit ok;
    instr_ready = 1'b1;
    do_reset();
    sync();
    jump_en   = 1'b1;
    jump_addr = 4'h7;
    sync();
    jump_en = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL jw_discard got valid=%b exp=0", instr_valid); end
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 4'h7) begin fails++; $display("FAIL jw_refetch got addr=%h rd=%b exp addr=7 rd=1", imem_addr, imem_rd_en); end
    wait_valid(10, ok);
    if (ok) begin
      checks++; if (instr !== 12'h107) begin fails++; $display("FAIL jw_instr got=%h exp=107", instr); end
    end
  endtask

  task automatic test_halt();
    instr_ready = 1'b1;
    do_reset();
    halt = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL halt_no_read got=%b exp=0", imem_rd_en); end
    sync();
    halt = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_halted k=%0d got=%b exp=1", k, halted); end
      checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL halt_rd_en k=%0d got=%b exp=0", k, imem_rd_en); end
      checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL halt_valid k=%0d got=%b exp=0", k, instr_valid); end
      jump_en   = 1'($urandom % 2);
      jump_addr = 4'($urandom_range(0, 15));
      sync();
    end
    do_reset();
    checks++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_cleared got=%b exp=0", halted); end
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 4'h0) begin fails++; $display("FAIL halt_restart got addr=%h rd=%b exp addr=0 rd=1", imem_addr, imem_rd_en); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    instr_ready = 1'b1;
    do_reset();
    for (int c = 0; c < PER + 1; c++) sync();
    checks++; if (imem_addr !== 4'h1 || imem_rd_en !== 1'b0) begin fails++; $display("FAIL rmw_pre got addr=%h rd=%b exp addr=1 rd=0", imem_addr, imem_rd_en); end
    reset = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rmw_valid got=%b exp=0", instr_valid); end
    checks++; if (imem_rd_en !== 1'b0) begin fails++; $display("FAIL rmw_rd_en got=%b exp=0", imem_rd_en); end
    checks++; if (imem_addr !== 4'h0) begin fails++; $display("FAIL rmw_pc got=%h exp=0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (accept_cnt !== 16'd0) begin fails++; $display("FAIL rmw_acc got=%0d exp=0", accept_cnt); end
`endif
    sync();
    reset = 1'b0;
    #1;
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 4'h0) begin fails++; $display("FAIL rmw_restart got addr=%h rd=%b exp addr=0 rd=1", imem_addr, imem_rd_en); end
    wait_valid(10, ok);
    if (ok) begin
      checks++; if (instr !== 12'h100) begin fails++; $display("FAIL rmw_instr got=%h exp=100", instr); end
    end
  endtask

  // Model: na is the address of the next word the controller should receive.
  // A handshake consumes na; any jump (outside halt) redirects na after that.
  task automatic test_random();
    int          na;
    int          acc;
    bit          prev_hold;
    logic [11:0] prev_instr;
    instr_ready = 1'b0;
    do_reset();
    na        = 0;
    acc       = 0;
    prev_hold = 1'b0;
    prev_instr = 12'h000;
    for (int i = 0; i < 400; i++) begin
      if (prev_hold) begin
        checks++; if (instr_valid !== 1'b1 || instr !== prev_instr) begin fails++; $display("FAIL rnd_hold i=%0d got v=%b instr=%h exp v=1 instr=%h", i, instr_valid, instr, prev_instr); end
      end
      if (imem_rd_en === 1'b1) begin
        checks++; if (imem_addr !== 4'(na)) begin fails++; $display("FAIL rnd_fetch_addr i=%0d got=%h exp=%h", i, imem_addr, 4'(na)); end
      end
      instr_ready = (($urandom % 10) < 7);
      jump_en     = (($urandom % 10) == 0);
      jump_addr   = 4'($urandom_range(0, 15));
      if (instr_valid === 1'b1 && instr_ready) begin
        checks++; if (instr !== 12'h100 + 12'(na)) begin fails++; $display("FAIL rnd_instr i=%0d got=%h exp=%h", i, instr, 12'h100 + 12'(na)); end
        na = (na + 1) % 16;
        acc++;
      end
      prev_hold  = (instr_valid === 1'b1) && !instr_ready && !jump_en;
      prev_instr = instr;
      if (jump_en) na = int'(jump_addr);
      sync();
    end
    jump_en     = 1'b0;
    instr_ready = 1'b0;
    checks++; if (acc < 20) begin fails++; $display("FAIL rnd_throughput got=%0d accepts exp>=20", acc); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (accept_cnt !== 16'(acc)) begin fails++; $display("FAIL rnd_accept_cnt got=%0d exp=%0d", accept_cnt, acc); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_wrap();
    test_jump_wait();
    test_halt();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
